// File: rtl/p1v_board_pkg.sv
// Board-level constants shared by the P1V LED logic.
// Supplies the default PWM and activity-stretch widths used by led_dimmer
// and led_stretch.
package p1v_board_pkg;

  // Default brightness resolution: 3 bits gives an 8-step PWM period.
  localparam int unsigned LED_PWM_BITS     = 3;

  // Default activity stretch: 2^20-1 cycles keeps a short blip visible.
  localparam int unsigned LED_STRETCH_BITS = 20;

endpackage : p1v_board_pkg

// File: rtl/led_stretch.sv
// One LED channel front end.
// Synchronises the raw activity input with two flops. It then stretches
// each pulse so that a one-cycle event is still visible to the eye.
// Build option: LED_DIMMER_STRETCH_EN.
//   When defined, a retriggerable down-counter keeps 'active' high for
//   2^STRETCH_BITS-1 cycles after the synchronised input falls.
//   When undefined, 'active' is simply the synchronised input.
module led_stretch
  import p1v_board_pkg::*;
#(
  parameter int unsigned STRETCH_BITS = LED_STRETCH_BITS
) (
  input  logic clock_160,
  input  logic nres,
  input  logic led_in,
  output logic active
);

  logic sync1_q;
  logic sync2_q;

  if (STRETCH_BITS == 0 || STRETCH_BITS > 24) begin : g_bad_stretch_bits
    $error("led_stretch: STRETCH_BITS must be in 1..24");
  end

  // Two-flop synchroniser; led_in may be asynchronous to clock_160.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= led_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef LED_DIMMER_STRETCH_EN
  logic [STRETCH_BITS-1:0] stretch_cnt_q;
  logic [STRETCH_BITS-1:0] stretch_cnt_d;

  // Reload on activity (retrigger), count down to zero, never wrap.
  always_comb begin
    stretch_cnt_d = stretch_cnt_q;
    if (sync2_q) begin
      stretch_cnt_d = '1;
    end else if (stretch_cnt_q != '0) begin
      stretch_cnt_d = stretch_cnt_q - STRETCH_BITS'(1);
    end else begin
      stretch_cnt_d = '0;
    end
  end

  // Stretch counter register.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      stretch_cnt_q <= '0;
    end else begin
      stretch_cnt_q <= stretch_cnt_d;
    end
  end

  assign active = sync2_q | (stretch_cnt_q != '0);
`else
  assign active = sync2_q;
`endif

endmodule : led_stretch

// File: rtl/led_dimmer.sv
// Multi-channel activity LED driver with per-channel PWM brightness.
// A shared free-running PWM counter compares against a per-channel duty.
// The duty is latched once per period so mid-period writes never glitch.
// Each output is gated by that channel's synchronised and optionally
// stretched activity.
// Build option: LED_DIMMER_STRETCH_EN enables the activity stretch in
// led_stretch.
module led_dimmer
  import p1v_board_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned PWM_BITS     = LED_PWM_BITS,
  parameter int unsigned STRETCH_BITS = LED_STRETCH_BITS
) (
  input  logic                         clock_160,
  input  logic                         nres,
  input  logic [NUM_LEDS-1:0]          led_in,
  input  logic [NUM_LEDS*PWM_BITS-1:0] duty,
  output logic [NUM_LEDS-1:0]          led_out
);

  logic [PWM_BITS-1:0]          pwm_cnt_q;
  logic [PWM_BITS-1:0]          pwm_cnt_d;
  logic [NUM_LEDS*PWM_BITS-1:0] duty_q;
  logic [NUM_LEDS*PWM_BITS-1:0] duty_d;
  logic [NUM_LEDS-1:0]          led_out_q;
  logic [NUM_LEDS-1:0]          led_out_d;
  logic [NUM_LEDS-1:0]          pwm_on;
  logic [NUM_LEDS-1:0]          active;

  if (NUM_LEDS == 0 || NUM_LEDS > 32) begin : g_bad_num_leds
    $error("led_dimmer: NUM_LEDS must be in 1..32");
  end
  if (PWM_BITS == 0 || PWM_BITS > 8) begin : g_bad_pwm_bits
    $error("led_dimmer: PWM_BITS must be in 1..8");
  end

  // Period counter; duty is sampled in the last slot of each period.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    if (pwm_cnt_q == '1) begin
      duty_d = duty;
    end else begin
      duty_d = duty_q;
    end
  end

  // PWM counter and latched duty registers.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    logic [PWM_BITS-1:0] ch_duty;

    assign ch_duty = duty_q[i*PWM_BITS +: PWM_BITS];
    // All-ones means fully on; zero falls out of the compare as always off.
    assign pwm_on[i] = (ch_duty == '1) || (pwm_cnt_q < ch_duty);

    led_stretch #(
      .STRETCH_BITS (STRETCH_BITS)
    ) u_stretch (
      .clock_160 (clock_160),
      .nres      (nres),
      .led_in    (led_in[i]),
      .active    (active[i])
    );
  end

  // Combine activity with the brightness waveform.
  always_comb begin
    led_out_d = active & pwm_on;
  end

  // Registered LED drive.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      led_out_q <= '0;
    end else begin
      led_out_q <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule : led_dimmer

// File: tb/tb_led_dimmer.sv
// Directed scoreboard bench for led_dimmer (8 channels, 3-bit PWM, 4-bit stretch).
// edge_n counts rising edges since the last reset release, so after edge e
// the PWM counter is e mod 8. Expected led_out values are pushed per edge
// and popped on the following falling edge.
module tb_led_dimmer;

`ifdef LED_DIMMER_STRETCH_EN
  localparam bit STRETCH_ON = 1'b1;
`else
  localparam bit STRETCH_ON = 1'b0;
`endif

  logic        clock_160 = 1'b0;
  logic        nres;
  logic [7:0]  led_in;
  logic [23:0] duty;
  logic [7:0]  led_out;

  int tests  = 0;
  int failed = 0;
  int edge_n = 0;
  logic [7:0] exp_q[$];

  led_dimmer #(
    .NUM_LEDS     (8),
    .PWM_BITS     (3),
    .STRETCH_BITS (4)
  ) dut (
    .clock_160 (clock_160),
    .nres      (nres),
    .led_in    (led_in),
    .duty      (duty),
    .led_out   (led_out)
  );

  always #5 clock_160 = ~clock_160;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock_160);
    edge_n++;
    @(negedge clock_160);
  endtask

  // Advance to edge 'last', comparing led_out against the scoreboard each edge.
  task automatic run_to(input int last, input string tag);
    logic [7:0] e;
    while (edge_n < last) begin
      tick();
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $error("FAIL %s: scoreboard empty at edge %0d, observed %0h", tag, edge_n, led_out);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s@%0d", tag, edge_n), {24'd0, led_out}, {24'd0, e});
      end
    end
  endtask

  task automatic set_duty(input int ch, input logic [2:0] v);
    duty[ch*3 +: 3] = v;
  endtask

  // ch0 duty 1 (high when pwm_cnt was 0), ch2 duty 2 then 6 from the next period.
  function automatic logic [7:0] exp_mid(input int e);
    logic b0;
    logic b2;
    b0 = (e >= 41) && ((e - 1) % 8 == 0);
    b2 = (e >= 65 && e <= 66) || (e >= 73 && e <= 78);
    return {5'b00000, b2, 1'b0, b0};
  endfunction

  // ch3 full on; pulses captured at edges 96, 104 and 136.
  function automatic logic [7:0] exp_pulse(input int e);
    logic b3;
    if (STRETCH_ON) b3 = (e >= 98 && e <= 121) || (e >= 138);
    else            b3 = (e == 98) || (e == 106) || (e == 138);
    return {4'b0000, b3, 3'b000};
  endfunction

  initial begin
    nres   = 1'b0;
    led_in = 8'h00;
    duty   = 24'h000000;
    repeat (2) @(negedge clock_160);
    check("reset_led_out", {24'd0, led_out}, 32'd0);
    check("reset_pwm_cnt", {29'd0, dut.pwm_cnt_q}, 32'd0);

    // Power-up: ch0 full on and active, but dark until the first duty latch.
    set_duty(0, 3'd7);
    led_in = 8'h01;
    nres   = 1'b1;
    edge_n = 0;
    for (int e = 1; e <= 16; e++) exp_q.push_back((e >= 9) ? 8'h01 : 8'h00);
    run_to(16, "powerup_full_on");

    // Duty to 0 mid-stream: latched at edge 24, dark from edge 25.
    set_duty(0, 3'd0);
    for (int e = 17; e <= 32; e++) exp_q.push_back((e <= 24) ? 8'h01 : 8'h00);
    run_to(32, "duty_zero");

    // Duty 1: one high cycle per period.
    set_duty(0, 3'd1);
    for (int e = 33; e <= 56; e++) exp_q.push_back(((e >= 41) && ((e - 1) % 8 == 0)) ? 8'h01 : 8'h00);
    run_to(56, "duty_one");

    // ch2 duty 2, changed to 6 when pwm_cnt is 3.
    set_duty(2, 3'd2);
    led_in = 8'h05;
    for (int e = 57; e <= 80; e++) exp_q.push_back(exp_mid(e));
    run_to(67, "mid_period");
    check("pwm_cnt_at_change", {29'd0, dut.pwm_cnt_q}, 32'd3);
    set_duty(2, 3'd6);
    run_to(80, "mid_period");

    // Stretch/retrigger on ch3 at full brightness.
    led_in = 8'h00;
    duty   = 24'h000000;
    set_duty(3, 3'd7);
    while (edge_n < 88) tick();
    for (int e = 89; e <= 142; e++) exp_q.push_back(exp_pulse(e));
    run_to(95, "stretch");
    led_in = 8'h08;
    run_to(96, "stretch");
    led_in = 8'h00;
    run_to(103, "stretch");
    led_in = 8'h08;
    run_to(104, "stretch");
    led_in = 8'h00;
    run_to(135, "stretch");
    led_in = 8'h08;
    run_to(136, "stretch");
    led_in = 8'h00;
    run_to(142, "stretch");

    // Asynchronous reset mid-period and mid-stretch.
    #2 nres = 1'b0;
    #1;
    check("async_reset_led_out", {24'd0, led_out}, 32'd0);
    check("async_reset_pwm_cnt", {29'd0, dut.pwm_cnt_q}, 32'd0);
    check("async_reset_duty_q", {8'd0, dut.duty_q}, 32'd0);
    led_in = 8'h08;
    repeat (3) @(negedge clock_160);
    check("held_reset_led_out", {24'd0, led_out}, 32'd0);

    // Release: dark until the first duty latch 8 edges later.
    nres   = 1'b1;
    edge_n = 0;
    for (int e = 1; e <= 16; e++) exp_q.push_back((e >= 9) ? 8'h08 : 8'h00);
    run_to(16, "rerelease");

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_led_dimmer
